dlfloat_result_deserializer: RTL and testbench

Host-side receiver for the MAC output byte stream. The MAC result port emits each 16-bit dlfloat result as two bytes, MSB first and then LSB, on consecutive byte slots. This block captures those bytes, realigns on an explicit sync pulse, and reassembles 16-bit words. It buffers the words in a small FIFO with a ready/valid output and decodes the dlfloat fields and special codes at the FIFO head. It sits on the test/FPGA side of the chip pins, in front of the checker or scoreboard logic.

---
 rtl/dlfloat_pkg.sv | 20 ++
 rtl/dlfloat_word_fifo.sv | 67 ++++++
 rtl/dlfloat_result_deserializer.sv | 125 ++++++++++++
 tb/tb_dlfloat_result_deserializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared dlfloat (1/6/9) definitions for the MAC result path and its host-side tooling.
package dlfloat_pkg;

    localparam int unsigned DLF_W      = 16;
    localparam int unsigned DLF_EXP_W  = 6;
    localparam int unsigned DLF_MANT_W = 9;
    localparam int unsigned DLF_BIAS   = 31;

    localparam logic [DLF_W-1:0] DLF_ZERO    = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_SPECIAL = 16'hFFFF;

    typedef enum logic {MSB_WAIT, LSB_WAIT} phase_e;

    typedef struct packed {
        logic                  sign;
        logic [DLF_EXP_W-1:0]  exp;
        logic [DLF_MANT_W-1:0] mant;
    } dlfloat_t;

endpackage

// File: rtl/dlfloat_word_fifo.sv
// Synchronous word FIFO; occupancy is tracked by a level counter, pointers wrap modulo DEPTH.
module dlfloat_word_fifo
    import dlfloat_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [DLF_W-1:0] push_data,
    input  logic             pop,
    output logic [DLF_W-1:0] head_data,
    output logic             head_valid,
    output logic [LVL_W-1:0] level,
    output logic             dropped
);

    logic [DLF_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        do_pop  = pop && !empty;
        // A full FIFO still accepts a push when the same edge frees a slot.
        do_push = push && (!full || do_pop);
        dropped = push && full && !do_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = !empty;
    assign level      = level_q;

endmodule

// File: rtl/dlfloat_result_deserializer.sv
// Reassembles MSB-first byte pairs from the MAC result pins into dlfloat words,
// buffers them and decodes the head word.
module dlfloat_result_deserializer
    import dlfloat_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    input  logic                    sync,
    input  logic                    clr_flags,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [5:0]              out_exp,
    output logic [8:0]              out_mant,
    output logic                    out_is_zero,
    output logic                    out_is_special,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    realign_err
);

    phase_e           phase_q, phase_d;
    logic [7:0]       msb_hold_q, msb_hold_d;
    logic [DLF_W-1:0] word_q, word_d;
    logic             push_q, push_d;
    logic             realign_set;
    logic             overflow_q, overflow_d;
    logic             realign_err_q, realign_err_d;
    logic             fifo_dropped;
    dlfloat_t         head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= MSB_WAIT;
            msb_hold_q <= '0;
            word_q     <= '0;
            push_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            msb_hold_q <= msb_hold_d;
            word_q     <= word_d;
            push_q     <= push_d;
        end
    end

    always_comb begin
        phase_d     = phase_q;
        msb_hold_d  = msb_hold_q;
        word_d      = word_q;
        push_d      = 1'b0;
        realign_set = 1'b0;
        case (phase_q)
            MSB_WAIT: begin
                if (byte_valid) begin
                    msb_hold_d = byte_in;
                    phase_d    = LSB_WAIT;
                end
            end
            LSB_WAIT: begin
                if (sync) begin
                    // A sync restarts the pair; a simultaneous byte becomes the new MSB.
                    realign_set = 1'b1;
                    if (byte_valid) begin
                        msb_hold_d = byte_in;
                        phase_d    = LSB_WAIT;
                    end else begin
                        msb_hold_d = '0;
                        phase_d    = MSB_WAIT;
                    end
                end else if (byte_valid) begin
                    word_d  = {msb_hold_q, byte_in};
                    push_d  = 1'b1;
                    phase_d = MSB_WAIT;
                end
            end
            default: phase_d = MSB_WAIT;
        endcase
    end

    dlfloat_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_q),
        .push_data  (word_q),
        .pop        (out_ready),
        .head_data  (out_data),
        .head_valid (out_valid),
        .level      (level),
        .dropped    (fifo_dropped)
    );

    // Sticky flags: a set in the same cycle as clr_flags wins.
    always_comb begin
        overflow_d    = fifo_dropped ? 1'b1 : (clr_flags ? 1'b0 : overflow_q);
        realign_err_d = realign_set  ? 1'b1 : (clr_flags ? 1'b0 : realign_err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q    <= 1'b0;
            realign_err_q <= 1'b0;
        end else begin
            overflow_q    <= overflow_d;
            realign_err_q <= realign_err_d;
        end
    end

    assign overflow    = overflow_q;
    assign realign_err = realign_err_q;

    assign head           = dlfloat_t'(out_data);
    assign out_sign       = head.sign;
    assign out_exp        = head.exp;
    assign out_mant       = head.mant;
    assign out_is_zero    = out_valid && (out_data == DLF_ZERO);
    assign out_is_special = out_valid && (out_data == DLF_SPECIAL);

endmodule

// File: tb/tb_dlfloat_result_deserializer.sv
// Bench for dlfloat_result_deserializer: table-driven decode vectors, scoreboard on pops,
// plus hand-written realign / overflow / full-FIFO / async-reset sequences.
module tb_dlfloat_result_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        sync = 1'b0;
    logic        clr_flags = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [5:0]  out_exp;
    logic [8:0]  out_mant;
    logic        out_is_zero;
    logic        out_is_special;
    logic [2:0]  level;
    logic        overflow;
    logic        realign_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb [$];
    logic [15:0] exp_w;

    typedef struct {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       sign;
        logic [5:0] exp;
        logic [8:0] mant;
        logic       is_zero;
        logic       is_special;
    } vec_t;

    vec_t vecs [6];

    dlfloat_result_deserializer #(
        .DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .sync           (sync),
        .clr_flags      (clr_flags),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sign       (out_sign),
        .out_exp        (out_exp),
        .out_mant       (out_mant),
        .out_is_zero    (out_is_zero),
        .out_is_special (out_is_special),
        .level          (level),
        .overflow       (overflow),
        .realign_err    (realign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Scoreboard: every accepted head word must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h required none", out_data);
            end else begin
                exp_w = sb.pop_front();
                check("word", out_data, exp_w);
                check("is_zero", out_is_zero, exp_w == 16'h0000);
                check("is_special", out_is_special, exp_w == 16'hFFFF);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic s);
        byte_in    = b;
        byte_valid = 1'b1;
        sync       = s;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        sync       = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic expect_kept);
        send_byte(w[15:8], 1'b0);
        if (expect_kept) sb.push_back(w);
        send_byte(w[7:0], 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
    endtask

    task automatic drain(input string name);
        int cnt = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && cnt < 50) begin
            tick(1);
            cnt++;
        end
        check({name, "_drained"}, (sb.size() == 0 && !out_valid), 1);
        check({name, "_level0"}, level, 0);
    endtask

    initial begin
        vecs[0] = '{8'h3E, 8'h00, 1'b0, 6'd31, 9'd0,   1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'hFF, 1'b1, 6'd63, 9'd511, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 6'd0,  9'd0,   1'b1, 1'b0};
        vecs[3] = '{8'hC1, 8'hA5, 1'b1, 6'd32, 9'd421, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 6'd63, 9'd511, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h00, 1'b1, 6'd0,  9'd0,   1'b0, 1'b0};

        #1 rst = 1'b1;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_realign", realign_err, 0);
        check("rst_is_zero", out_is_zero, 0);
        check("rst_is_special", out_is_special, 0);
        rst = 1'b0;
        tick(1);

        // Decode table: one word at a time, checking latency and head fields.
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].msb, 1'b0);
            sb.push_back({vecs[i].msb, vecs[i].lsb});
            send_byte(vecs[i].lsb, 1'b0);
            check("latency_not_yet", out_valid, 0);
            tick(1);
            check("head_valid", out_valid, 1);
            check("head_sign", out_sign, vecs[i].sign);
            check("head_exp", out_exp, vecs[i].exp);
            check("head_mant", out_mant, vecs[i].mant);
            check("head_zero", out_is_zero, vecs[i].is_zero);
            check("head_special", out_is_special, vecs[i].is_special);
            tick(1);
            check("one_cycle_valid", out_valid, 0);
        end
        check("flags_clean_ovf", overflow, 0);
        check("flags_clean_realign", realign_err, 0);

        // Back-to-back FF FF 00 00.
        send_word(16'hFFFF, 1'b1);
        send_word(16'h0000, 1'b1);
        drain("b2b");

        // Sync together with a byte while in LSB_WAIT.
        send_byte(8'h41, 1'b0);
        send_byte(8'h7C, 1'b1);
        check("realign_set", realign_err, 1);
        sb.push_back(16'h7C80);
        send_byte(8'h80, 1'b0);
        drain("realign");
        pulse_clr();
        check("realign_clr", realign_err, 0);

        // Sync alone in MSB_WAIT is harmless.
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        check("sync_msb_noop", realign_err, 0);

        // Lone sync in LSB_WAIT with clr_flags in the same cycle: set wins, MSB discarded.
        send_byte(8'h41, 1'b0);
        sync = 1'b1;
        clr_flags = 1'b1;
        tick(1);
        sync = 1'b0;
        clr_flags = 1'b0;
        check("set_beats_clr", realign_err, 1);
        send_word(16'h7C80, 1'b1);
        drain("sync_only");
        pulse_clr();

        // Overflow: five words into a depth-4 FIFO with the consumer stalled.
        out_ready = 1'b0;
        send_word(16'h1001, 1'b1);
        send_word(16'h2002, 1'b1);
        send_word(16'h3003, 1'b1);
        send_word(16'h4004, 1'b1);
        send_word(16'h5005, 1'b0);
        tick(1);
        check("ovf_level", level, 4);
        check("ovf_flag", overflow, 1);
        pulse_clr();
        check("ovf_clr", overflow, 0);
        drain("ovf");

        // Full FIFO: LSB push lands on the same edge as a pop.
        out_ready = 1'b0;
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b1);
        send_word(16'h3333, 1'b1);
        send_word(16'h4444, 1'b1);
        tick(1);
        check("full_level", level, 4);
        send_word(16'h5AA5, 1'b1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("pushpop_level", level, 4);
        check("pushpop_ovf", overflow, 0);
        drain("pushpop");

        // Asynchronous reset mid-word with a word already buffered.
        out_ready = 1'b0;
        send_word(16'h0F0F, 1'b0);
        tick(1);
        check("pre_rst_level", level, 1);
        send_byte(8'h12, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_valid", out_valid, 0);
        tick(1);
        rst = 1'b0;
        out_ready = 1'b1;
        send_word(16'hABCD, 1'b1);
        check("post_rst_realign", realign_err, 0);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
